// File: rtl/conv_pkg.sv
// Shared definitions for the 7x7 window generator and the convolution block.
// Holds window geometry, the frame-state encoding and the column-shift helper.
package conv_pkg;

  localparam int WIN   = 7;
  localparam int PIX_W = 8;
  localparam int ROW_W = WIN * PIX_W;
  localparam int LINES = WIN - 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } frame_state_t;

  // Newest pixel enters at element WIN-1 (the MSBs) and every other element moves one slot toward 0.
  function automatic logic [ROW_W-1:0] shift_col(input logic [ROW_W-1:0] r,
                                                 input logic [PIX_W-1:0] px);
    return {px, r[ROW_W-1:PIX_W]};
  endfunction

endpackage

// File: rtl/line_ram.sv
// Simple dual-port line buffer: one write port, one synchronous read port.
// The read data holds its value when no read is issued.
module line_ram #(
  parameter int DEPTH  = 640,
  parameter int DATA_W = 8,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/window_gen_7x7.sv
// Raster pixel stream to 7x7 neighbourhood for the convolution block.
// Optional macro WINGEN_COORD_EN adds the window-centre outputs win_x / win_y.
module window_gen_7x7
  import conv_pkg::*;
#(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  input  logic             pix_sof,
  output logic [ROW_W-1:0] row0,
  output logic [ROW_W-1:0] row1,
  output logic [ROW_W-1:0] row2,
  output logic [ROW_W-1:0] row3,
  output logic [ROW_W-1:0] row4,
  output logic [ROW_W-1:0] row5,
  output logic [ROW_W-1:0] row6,
  output logic             win_valid,
  output logic             overrun
`ifdef WINGEN_COORD_EN
  ,
  output logic [9:0]       win_x,
  output logic [8:0]       win_y
`endif
);

  localparam int COL_W  = $clog2(IMG_W);
  localparam int ROW_CW = $clog2(IMG_H);

  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_CW-1:0] ROW_LAST = ROW_CW'(IMG_H - 1);
  localparam logic [COL_W-1:0]  COL_WIN  = COL_W'(WIN - 1);
  localparam logic [ROW_CW-1:0] ROW_WIN  = ROW_CW'(WIN - 1);

  frame_state_t      state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d, cur_col;
  logic [ROW_CW-1:0] row_q, row_d, cur_row;
  logic              ovr_q, ovr_d;
  logic              accept;
  logic              in_win;

  logic              vld_p0, win_ok_p0;
  logic [PIX_W-1:0]  pix_p0;
  logic [COL_W-1:0]  col_p0;

  logic              vld_p1, win_ok_p1;
  logic [PIX_W-1:0]  pix_p1;
  logic [COL_W-1:0]  col_p1;
  logic [PIX_W-1:0]  rd_p1   [LINES];
  logic [PIX_W-1:0]  wr_data [LINES];
  logic [WIN-1:0][PIX_W-1:0] newcol_p1;

  logic              vld_p2;
  logic [WIN-1:0][ROW_W-1:0] win_p2;

  // Frame control: a sof always restarts at (0,0); other pixels count only while RUN.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    ovr_d   = ovr_q;
    accept  = 1'b0;
    cur_col = col_q;
    cur_row = row_q;
    if (pix_valid) begin
      if (pix_sof) begin
        accept  = 1'b1;
        cur_col = '0;
        cur_row = '0;
        state_d = RUN;
        ovr_d   = 1'b0;
      end else if (state_q == RUN) begin
        accept = 1'b1;
      end else if (state_q == DONE) begin
        ovr_d = 1'b1;
      end
      if (accept) begin
        if (cur_col == COL_LAST) begin
          col_d = '0;
          if (cur_row == ROW_LAST) begin
            row_d   = '0;
            state_d = DONE;
          end else begin
            row_d = cur_row + 1'b1;
          end
        end else begin
          col_d = cur_col + 1'b1;
          row_d = cur_row;
        end
      end
    end
  end

  assign in_win = (cur_row >= ROW_WIN) && (cur_col >= COL_WIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      ovr_q   <= ovr_d;
    end
  end

  // ---- stage p0: accepted pixel and its column address ----
  always_ff @(posedge clk) begin
    if (accept) begin
      pix_p0 <= pix_in;
      col_p0 <= cur_col;
    end
  end

  // ---- stage p1: line RAM read and delayed input pixel ----
  always_ff @(posedge clk) begin
    if (vld_p0) begin
      pix_p1 <= pix_p0;
      col_p1 <= col_p0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0    <= 1'b0;
      win_ok_p0 <= 1'b0;
      vld_p1    <= 1'b0;
      win_ok_p1 <= 1'b0;
      vld_p2    <= 1'b0;
    end else begin
      vld_p0    <= accept;
      win_ok_p0 <= accept && in_win;
      vld_p1    <= vld_p0;
      win_ok_p1 <= vld_p0 && win_ok_p0;
      vld_p2    <= vld_p1 && win_ok_p1;
    end
  end

  // Cascade write lands one cycle after the read of the same column, so line k
  // receives line k-1's pre-write contents straight from the RAM output.
  for (genvar gi = 0; gi < LINES; gi++) begin : g_line
    if (gi == 0) begin : g_head
      assign wr_data[gi] = pix_p1;
    end else begin : g_tail
      assign wr_data[gi] = rd_p1[gi-1];
    end

    line_ram #(
      .DEPTH (IMG_W),
      .DATA_W(PIX_W)
    ) u_ram (
      .clk  (clk),
      .we   (vld_p1),
      .waddr(col_p1),
      .wdata(wr_data[gi]),
      .re   (vld_p0),
      .raddr(col_p0),
      .rdata(rd_p1[gi])
    );
  end

  // Line 0 holds the previous image line, so RAM k feeds window row WIN-2-k.
  always_comb begin
    newcol_p1[WIN-1] = pix_p1;
    for (int k = 0; k < LINES; k++) begin
      newcol_p1[LINES-1-k] = rd_p1[k];
    end
  end

  // ---- stage p2: window register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_p2 <= '0;
    end else if (vld_p1) begin
      for (int j = 0; j < WIN; j++) begin
        win_p2[j] <= shift_col(win_p2[j], newcol_p1[j]);
      end
    end
  end

  assign row0      = win_p2[0];
  assign row1      = win_p2[1];
  assign row2      = win_p2[2];
  assign row3      = win_p2[3];
  assign row4      = win_p2[4];
  assign row5      = win_p2[5];
  assign row6      = win_p2[6];
  assign win_valid = vld_p2;
  assign overrun   = ovr_q;

`ifdef WINGEN_COORD_EN
  logic [ROW_CW-1:0] row_p0, row_p1;

  always_ff @(posedge clk) begin
    if (accept) begin
      row_p0 <= cur_row;
    end
    if (vld_p0) begin
      row_p1 <= row_p0;
    end
  end

  // Centre of the window is three pixels up and left of its bottom-right corner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_x <= '0;
      win_y <= '0;
    end else if (vld_p1 && win_ok_p1) begin
      win_x <= 10'(col_p1) - 10'd3;
      win_y <= 9'(row_p1) - 9'd3;
    end
  end
`endif

endmodule

// File: tb/tb_window_gen_7x7.sv
// Scoreboard bench for window_gen_7x7 on an 8x8 image with a frame-buffer reference model.
// Build with WINGEN_COORD_EN defined to also check win_x / win_y.
module tb_window_gen_7x7;
  import conv_pkg::*;

  localparam int W = 8;
  localparam int H = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [PIX_W-1:0] pix_in = '0;
  logic             pix_valid = 1'b0;
  logic             pix_sof = 1'b0;
  logic [ROW_W-1:0] row0, row1, row2, row3, row4, row5, row6;
  logic             win_valid, overrun;
`ifdef WINGEN_COORD_EN
  logic [9:0]       win_x;
  logic [8:0]       win_y;
`endif

  window_gen_7x7 #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_valid(pix_valid), .pix_sof(pix_sof),
    .row0(row0), .row1(row1), .row2(row2), .row3(row3), .row4(row4), .row5(row5), .row6(row6),
    .win_valid(win_valid), .overrun(overrun)
`ifdef WINGEN_COORD_EN
    , .win_x(win_x), .win_y(win_y)
`endif
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned          cyc;
    logic [WIN*ROW_W-1:0] win;
    int                   x;
    int                   y;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_win  = 0;
  int   w0;

  // Reference model: the current frame as a plain 2-D array plus frame position/state.
  logic [PIX_W-1:0] frame [H][W];
  int   m_state = 0;  // 0 idle, 1 running, 2 frame complete
  int   m_col = 0;
  int   m_row = 0;
  logic exp_ovr = 1'b0;

  task automatic model_reset();
    m_state = 0; m_col = 0; m_row = 0; exp_ovr = 1'b0;
    q.delete();
  endtask

  task automatic push_win(input int unsigned cy);
    exp_t e;
    e.cyc = cy;
    e.win = '0;
    for (int j = 0; j < WIN; j++)
      for (int k = 0; k < WIN; k++)
        e.win[(j*WIN + k)*PIX_W +: PIX_W] = frame[m_row-6+j][m_col-6+k];
    e.x = m_col - 3;
    e.y = m_row - 3;
    q.push_back(e);
  endtask

  // One input cycle; the window of an accepted pixel is due three negedges later.
  task automatic step(input bit v, input bit s, input logic [PIX_W-1:0] d);
    bit acc;
    @(negedge clk);
    pix_valid = v; pix_sof = s; pix_in = d;
    acc = 1'b0;
    if (v) begin
      if (s) begin
        m_state = 1; m_col = 0; m_row = 0; exp_ovr = 1'b0; acc = 1'b1;
      end else if (m_state == 1) begin
        acc = 1'b1;
      end else if (m_state == 2) begin
        exp_ovr = 1'b1;
      end
      if (acc) begin
        frame[m_row][m_col] = d;
        if (m_row >= 6 && m_col >= 6) push_win(cyc + 3);
        if (m_col == W-1) begin
          m_col = 0;
          if (m_row == H-1) begin m_row = 0; m_state = 2; end
          else m_row++;
        end else begin
          m_col++;
        end
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'($urandom_range(1)), 8'($urandom));
  endtask

  task automatic send_frame(input int gap_pct, input bit rnd, input int npix);
    int r, c;
    for (int i = 0; i < npix; i++) begin
      r = i / W;
      c = i % W;
      while ($urandom_range(99) < gap_pct) idle(1);
      step(1'b1, (i == 0), rnd ? 8'($urandom) : 8'(8*r + c));
    end
  endtask

  task automatic chk_cnt(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
    end
  endtask

  task automatic chk_ovr(input string nm);
    checks++;
    if (overrun !== exp_ovr) begin
      errors++;
      $display("FAIL %s: overrun=%b, expected %b", nm, overrun, exp_ovr);
    end
  endtask

  task automatic chk_reset(input string nm);
    checks += 3;
    if ({row6, row5, row4, row3, row2, row1, row0} !== '0) begin
      errors++;
      $display("FAIL %s_rows: got %h, expected 0", nm, {row6, row5, row4, row3, row2, row1, row0});
    end
    if (win_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s_valid: got %b, expected 0", nm, win_valid);
    end
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL %s_overrun: got %b, expected 0", nm, overrun);
    end
`ifdef WINGEN_COORD_EN
    checks++;
    if (win_x !== '0 || win_y !== '0) begin
      errors++;
      $display("FAIL %s_coord: got (%0d,%0d), expected (0,0)", nm, win_x, win_y);
    end
`endif
  endtask

  // Monitor: every output window is popped from the scoreboard and compared.
  exp_t                 mon_e;
  logic [WIN*ROW_W-1:0] got;
  always @(negedge clk) begin
    if (rst_n) begin
      if (win_valid) begin
        n_win++;
        checks++;
        got = {row6, row5, row4, row3, row2, row1, row0};
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_window: cyc=%0d got %h, expected none", cyc, got);
        end else begin
          mon_e = q.pop_front();
          if (mon_e.cyc != cyc || got !== mon_e.win) begin
            errors++;
            $display("FAIL window: cyc=%0d got %h, expected cyc=%0d %h", cyc, got, mon_e.cyc, mon_e.win);
          end
`ifdef WINGEN_COORD_EN
          checks++;
          if (int'(win_x) != mon_e.x || int'(win_y) != mon_e.y) begin
            errors++;
            $display("FAIL coord: got (%0d,%0d), expected (%0d,%0d)", win_x, win_y, mon_e.x, mon_e.y);
          end
`endif
        end
      end else if (q.size() != 0 && q[0].cyc <= cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_window: cyc=%0d win_valid=0, expected window due at cyc=%0d", cyc, q[0].cyc);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not complete, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset("reset_state");
    rst_n = 1'b1;

    // Pixels without sof after reset are ignored.
    w0 = n_win;
    repeat (6) step(1'b1, 1'b0, 8'($urandom));
    idle(3);
    chk_cnt("idle_discard_windows", n_win - w0, 0);
    chk_ovr("idle_no_overrun");

    w0 = n_win;
    send_frame(0, 1'b0, W*H);
    idle(4);
    chk_cnt("b2b_windows", n_win - w0, 4);

    w0 = n_win;
    send_frame(50, 1'b0, W*H);
    idle(4);
    chk_cnt("gap_windows", n_win - w0, 4);

    // Next frame's sof two cycles behind the previous frame's last pixel.
    w0 = n_win;
    send_frame(0, 1'b0, W*H);
    idle(1);
    send_frame(0, 1'b1, W*H);
    idle(4);
    chk_cnt("close_sof_windows", n_win - w0, 8);

    // Mid-frame sof at (3,4): random frame 1, then a full frame 2.
    w0 = n_win;
    send_frame(0, 1'b1, 4*W + 3);
    send_frame(0, 1'b0, W*H);
    idle(4);
    chk_cnt("mid_sof_windows", n_win - w0, 4);

    // Overrun: three pixels after a completed frame.
    w0 = n_win;
    repeat (3) step(1'b1, 1'b0, 8'($urandom));
    idle(3);
    chk_cnt("overrun_windows", n_win - w0, 0);
    chk_ovr("overrun_set");
    send_frame(0, 1'b0, 1);
    idle(1);
    chk_ovr("overrun_cleared");
    w0 = n_win;
    send_frame(30, 1'b1, W*H);
    idle(4);
    chk_cnt("after_overrun_windows", n_win - w0, 4);

    // Asynchronous reset mid-cycle while overrun is set.
    repeat (2) step(1'b1, 1'b0, 8'($urandom));
    idle(1);
    chk_ovr("overrun_set_again");
    @(posedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1 chk_reset("async_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    w0 = n_win;
    repeat (4) step(1'b1, 1'b0, 8'($urandom));
    idle(3);
    chk_cnt("post_reset_discard", n_win - w0, 0);
    chk_ovr("post_reset_overrun");

    // Reset at pixel 40 of a frame, then stray pixels, then a clean frame.
    send_frame(0, 1'b0, 40);
    @(negedge clk);
    pix_valid = 1'b1; pix_sof = 1'b0; pix_in = 8'd40;
    rst_n = 1'b0;
    model_reset();
    #1 chk_reset("reset_mid_frame");
    @(negedge clk);
    pix_valid = 1'b0;
    rst_n = 1'b1;
    w0 = n_win;
    repeat (3) step(1'b1, 1'b0, 8'($urandom));
    send_frame(0, 1'b0, W*H);
    idle(4);
    chk_cnt("post_reset_frame_windows", n_win - w0, 4);

    idle(4);
    chk_cnt("scoreboard_drained", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
